// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// Module   : imem_loader
// Brief    : Byte-stream loader writing 16-bit instruction words into the
//            instruction memory; holds the CPU in reset until a valid image
//            has been received. LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [7:0]        InData,
    input  logic              InValid,
    output logic              InReady,
    output logic              ImWe,
    output logic [ADDR_W-1:0] ImAddr,
    output logic [15:0]       ImWData,
    output logic              CpuRst,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR_LO = 4'd1,
        S_ADDR_HI = 4'd2,
        S_CNT_LO  = 4'd3,
        S_CNT_HI  = 4'd4,
        S_DATA_LO = 4'd5,
        S_DATA_HI = 4'd6,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK   = 4'd7,
`endif
        S_DONE    = 4'd8,
        S_ERR     = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          lo_q, lo_d;        // low byte of the field in flight
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;
    logic                in_frame;
    logic                finish;
    logic [ADDR_W-1:0]   start_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    assign InReady    = 1'b1;
    assign accept     = InValid;
    assign start_addr = ADDR_W'({InData, lo_q});

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        nxt_addr_d = nxt_addr_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        in_frame   = 1'b0;
        finish     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        if (accept) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (InData == SYNC_BYTE) begin
                        state_d   = S_ADDR_LO;
                        cpu_rst_d = 1'b1;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        chk_d     = 8'h00;
`endif
                    end
                end
                S_ADDR_LO: begin
                    in_frame = 1'b1;
                    lo_d     = InData;
                    state_d  = S_ADDR_HI;
                end
                S_ADDR_HI: begin
                    in_frame = 1'b1;
                    // Instruction words are 16-bit aligned; odd start is fatal.
                    if (lo_q[0]) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        nxt_addr_d = start_addr;
                        state_d    = S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    in_frame = 1'b1;
                    lo_d     = InData;
                    state_d  = S_CNT_HI;
                end
                S_CNT_HI: begin
                    in_frame = 1'b1;
                    cnt_d    = {InData, lo_q};
                    if ({InData, lo_q} == 16'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    in_frame = 1'b1;
                    lo_d     = InData;
                    state_d  = S_DATA_HI;
                end
                S_DATA_HI: begin
                    in_frame   = 1'b1;
                    we_d       = 1'b1;
                    addr_d     = nxt_addr_q;
                    wdata_d    = {InData, lo_q};
                    nxt_addr_d = nxt_addr_q + ADDR_W'(2);
                    cnt_d      = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (InData == chk_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        if (finish) begin
`ifdef LOADER_CHECKSUM_EN
            state_d   = S_CHECK;
`else
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        if (in_frame) begin
            chk_d = chk_q ^ InData;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            lo_q       <= 8'h00;
            cnt_q      <= 16'h0000;
            nxt_addr_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            nxt_addr_q <= nxt_addr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign ImWe    = we_q;
    assign ImAddr  = addr_q;
    assign ImWData = wdata_q;
    assign CpuRst  = cpu_rst_q;
    assign Done    = done_q;
    assign Err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_loader
// Brief    : Frame-level model of the loader: builds byte frames, predicts the
//            memory writes and final status, and checks the DUT against them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  InData;
    logic        InValid;
    logic        InReady;
    logic        ImWe;
    logic [15:0] ImAddr;
    logic [15:0] ImWData;
    logic        CpuRst;
    logic        Done;
    logic        Err;

    imem_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid),
        .InReady(InReady), .ImWe(ImWe), .ImAddr(ImAddr), .ImWData(ImWData),
        .CpuRst(CpuRst), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    logic [15:0] wq[$];
    bit          gaps_en = 1'b0;
    logic        exp_done, exp_err, exp_cpu;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the next predicted (address, data) pair.
    always @(negedge Clk) begin
        wr_t w;
        if (ImWe === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(ImWe), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(ImAddr), 32'(w.a));
                check("wr_data", 32'(ImWData), 32'(w.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        if (gaps_en) begin
            repeat ($urandom_range(0, 2)) begin
                InValid = 1'b0;
                InData  = 8'($urandom);
                @(posedge Clk); #1;
            end
        end
        InData  = b;
        InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        InData  = 8'($urandom);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"},   32'(Done),   32'(exp_done));
        check({tag, "_err"},    32'(Err),    32'(exp_err));
        check({tag, "_cpurst"}, 32'(CpuRst), 32'(exp_cpu));
    endtask

    // Sends one frame built from wq; predicts writes and the resulting status.
    task automatic run_frame(input logic [15:0] addr, input bit bad, input int junk);
        logic [7:0]  body[$];
        logic [7:0]  chk;
        logic [7:0]  jb;
        logic [15:0] n;
        wr_t         w;
        for (int i = 0; i < junk; i++) begin
            do jb = 8'($urandom); while (jb == 8'hA5);
            send_byte(jb);
        end
        if (junk > 0) check_status("junk");
        send_byte(8'hA5);
        exp_done = 1'b0; exp_err = 1'b0; exp_cpu = 1'b1;
        check_status("sync");
        body.push_back(addr[7:0]);
        body.push_back(addr[15:8]);
        if (addr[0]) begin
            exp_err = 1'b1;
        end else begin
            n = 16'(wq.size());
            body.push_back(n[7:0]);
            body.push_back(n[15:8]);
            for (int i = 0; i < wq.size(); i++) begin
                body.push_back(wq[i][7:0]);
                body.push_back(wq[i][15:8]);
                w.a = addr + 16'(2 * i);
                w.d = wq[i];
                exp_q.push_back(w);
            end
            chk = 8'h00;
            foreach (body[i]) chk = chk ^ body[i];
            if (CHK_EN) body.push_back(bad ? (chk ^ 8'h01) : chk);
            if (bad && CHK_EN) begin
                exp_err = 1'b1;
            end else begin
                exp_done = 1'b1;
                exp_cpu  = 1'b0;
            end
        end
        foreach (body[i]) send_byte(body[i]);
        check_status("frame_end");
        @(negedge Clk); #1;
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        Rst = 1'b1; InValid = 1'b0; InData = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        exp_done = 1'b0; exp_err = 1'b0; exp_cpu = 1'b1;
        check("rst_inready", 32'(InReady), 32'd1);
        check("rst_we",      32'(ImWe),    32'd0);
        check("rst_addr",    32'(ImAddr),  32'd0);
        check("rst_wdata",   32'(ImWData), 32'd0);
        check_status("rst");
        Rst = 1'b0;

        // Basic two-word load at address 0.
        wq = '{16'h1234, 16'h5678};
        run_frame(16'h0000, 1'b0, 0);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum: words land, but the image is rejected.
        wq = '{16'h1234, 16'h5678};
        run_frame(16'h0000, 1'b1, 0);
        wq = '{16'h1234, 16'h5678};
        run_frame(16'h0000, 1'b0, 0);
`endif

        // Odd start address aborts before any write.
        wq.delete();
        run_frame(16'h0001, 1'b0, 0);

        // Address wrap at the top of the space.
        wq = '{16'hBEEF, 16'hCAFE};
        run_frame(16'hFFFE, 1'b0, 0);

        // Empty payload.
        wq.delete();
        run_frame(16'h0010, 1'b0, 0);

        // Randomized frames with junk before SYNC and InValid gaps.
        gaps_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wq.delete();
            for (int i = 0; i < f; i++) wq.push_back(16'($urandom));
            if (f > 1) wq[1] = {wq[1][15:8], 8'hA5};
            run_frame(16'($urandom) & 16'hFFFE, 1'b0, int'($urandom_range(1, 4)));
        end
        gaps_en = 1'b0;

        // Reset in the middle of the payload.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
        Rst = 1'b1;
        @(posedge Clk); #1;
        exp_done = 1'b0; exp_err = 1'b0; exp_cpu = 1'b1;
        check("midrst_we",    32'(ImWe),    32'd0);
        check("midrst_addr",  32'(ImAddr),  32'd0);
        check("midrst_wdata", 32'(ImWData), 32'd0);
        check("midrst_ready", 32'(InReady), 32'd1);
        check_status("midrst");
        Rst = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check_status("post_rst");

        wq = '{16'h0A0B, 16'hA5A5, 16'h1357};
        run_frame(16'h0200, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
